// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bank: command layout, FSM encoding and
// synchroniser depth.
package spi_reg_pkg;

    localparam int CMD_WR_BIT  = 7;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, followed by one history flop
// that turns the synchronised level into single-cycle rise/fall strobes.
module spi_sync_edge
    import spi_reg_pkg::*;
#(
    parameter logic RST_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // next state of the synchroniser chain and edge-history flop
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // synchroniser and history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_LVL}};
            prev_q <= RST_LVL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Mode-0 SPI slave register bank: RW byte registers, RO mirror readback, burst
// auto-increment and a hardware write port that loses to SPI commits.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int         RW_REG_COUNT = 23,
    parameter int         RO_REG_COUNT = 1,
    parameter int         ADDR_W       = 7,
    parameter int         AUTO_INC     = 1,
    parameter logic [7:0] RST_VAL      = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spi_cs,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    input  logic                      hw_we,
    input  logic [ADDR_W-1:0]         hw_addr,
    input  logic [7:0]                hw_wdata,
    input  logic [8*RO_REG_COUNT-1:0] ro_flat,
    output logic [8*RW_REG_COUNT-1:0] rw_flat,
    output logic                      wr_pulse,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic                      hw_drop,
    output logic                      frame_err
);

    logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    spi_sync_edge #(.RST_LVL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .d(spi_clk), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_sync_edge #(.RST_LVL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .d(spi_cs), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              miso_q, miso_d;
    logic              commit_q, commit_d;
    logic [ADDR_W-1:0] commit_addr_q, commit_addr_d;
    logic [7:0]        commit_data_q, commit_data_d;
    logic [7:0]        regs_q [RW_REG_COUNT];
    logic [7:0]        regs_d [RW_REG_COUNT];
    logic              wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              hw_drop_q, hw_drop_d;
    logic              frame_err_q, frame_err_d;

    logic [7:0]        byte_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [7:0]        rd_byte_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_sel_addr_s;
    logic [7:0]        wr_sel_data_s;

    // completed byte, post-byte address and read-source mux
    always_comb begin
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
        byte_s      = {rx_q, mosi_sync_q[1]};
        next_addr_s = (AUTO_INC != 0) ? (addr_q + {{(ADDR_W-1){1'b0}}, 1'b1}) : addr_q;
        rd_addr_s   = (state_q == CMD) ? byte_s[ADDR_W-1:0] : next_addr_s;
        rd_byte_s   = 8'h00;
        for (int i = 0; i < RW_REG_COUNT; i++) begin
            rd_byte_s = (rd_addr_s == ADDR_W'(i)) ? regs_q[i] : rd_byte_s;
        end
        for (int i = 0; i < RO_REG_COUNT; i++) begin
            rd_byte_s = (rd_addr_s == ADDR_W'(RW_REG_COUNT + i)) ? ro_flat[8*i +: 8] : rd_byte_s;
        end
    end

    // one register write per cycle; a pending SPI commit always beats hw_we
    always_comb begin
        wr_en_s       = 1'b0;
        wr_sel_addr_s = commit_addr_q;
        wr_sel_data_s = commit_data_q;
        hw_drop_d     = 1'b0;
        if (commit_q) begin
            wr_en_s   = 1'b1;
            hw_drop_d = hw_we;
        end else if (hw_we) begin
            wr_sel_addr_s = hw_addr;
            wr_sel_data_s = hw_wdata;
            wr_en_s       = (int'(hw_addr) < RW_REG_COUNT);
            hw_drop_d     = (int'(hw_addr) >= RW_REG_COUNT);
        end else begin
            wr_en_s = 1'b0;
        end
        for (int i = 0; i < RW_REG_COUNT; i++) begin
            regs_d[i] = (wr_en_s && (wr_sel_addr_s == ADDR_W'(i))) ? wr_sel_data_s : regs_q[i];
        end
        wr_pulse_d = wr_en_s;
        wr_addr_d  = wr_en_s ? wr_sel_addr_s : wr_addr_q;
    end

    // SPI frame FSM: CS edges take priority over SCLK edges
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        addr_d        = addr_q;
        miso_d        = miso_q;
        commit_d      = 1'b0;
        commit_addr_d = commit_addr_q;
        commit_data_d = commit_data_q;
        frame_err_d   = frame_err_q;
        if (cs_rise_s) begin
            state_d     = IDLE;
            frame_err_d = frame_err_q | (bit_cnt_q != 3'd0);
            bit_cnt_d   = 3'd0;
            miso_d      = 1'b0;
        end else if (cs_fall_s) begin
            state_d     = CMD;
            bit_cnt_d   = 3'd0;
            frame_err_d = 1'b0;
            miso_d      = 1'b0;
        end else if (state_q == IDLE) begin
            miso_d = 1'b0;
        end else if (sclk_rise_s) begin
            rx_d      = byte_s[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    CMD: begin
                        addr_d = byte_s[ADDR_W-1:0];
                        if (byte_s[CMD_WR_BIT]) begin
                            state_d = WDATA;
                        end else begin
                            state_d = RDATA;
                            tx_d    = rd_byte_s;
                        end
                    end
                    WDATA: begin
                        commit_d      = (int'(addr_q) < RW_REG_COUNT);
                        commit_addr_d = addr_q;
                        commit_data_d = byte_s;
                        addr_d        = next_addr_s;
                    end
                    RDATA: begin
                        tx_d   = rd_byte_s;
                        addr_d = next_addr_s;
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                addr_d = addr_q;
            end
        end else if (sclk_fall_s) begin
            if (state_q == RDATA) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end else begin
                miso_d = 1'b0;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // all sequential state of the bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q   <= 2'b00;
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            rx_q          <= 7'd0;
            tx_q          <= 8'h00;
            addr_q        <= '0;
            miso_q        <= 1'b0;
            commit_q      <= 1'b0;
            commit_addr_q <= '0;
            commit_data_q <= 8'h00;
            regs_q        <= '{default: RST_VAL};
            wr_pulse_q    <= 1'b0;
            wr_addr_q     <= '0;
            hw_drop_q     <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            mosi_sync_q   <= mosi_sync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            addr_q        <= addr_d;
            miso_q        <= miso_d;
            commit_q      <= commit_d;
            commit_addr_q <= commit_addr_d;
            commit_data_q <= commit_data_d;
            regs_q        <= regs_d;
            wr_pulse_q    <= wr_pulse_d;
            wr_addr_q     <= wr_addr_d;
            hw_drop_q     <= hw_drop_d;
            frame_err_q   <= frame_err_d;
        end
    end

    for (genvar g = 0; g < RW_REG_COUNT; g++) begin : g_flat
        assign rw_flat[8*g +: 8] = regs_q[g];
    end

    assign spi_miso  = miso_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign hw_drop   = hw_drop_q;
    assign frame_err = frame_err_q;

endmodule
